// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: wide adder built by stepping a shared 4-bit CLA nibble by nibble.
// Optional macro CLA_RECHECK_EN adds recompute-and-compare with bounded retry.
module cla_word_sequencer #(
  parameter int NIBBLES   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   err,
  output logic                   busy,
  output logic [3:0]             cla_a,
  output logic [3:0]             cla_b,
  output logic                   cla_cin,
  input  logic [3:0]             cla_sum,
  input  logic                   cla_cout
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IW    = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

`ifdef CLA_RECHECK_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin0;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_commit;
  logic             w_active;
  logic             w_last;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;

`ifdef CLA_RECHECK_EN
  logic             r_err;
  logic [3:0]       r_sh_sum;
  logic             r_sh_cout;
  logic [RW-1:0]    r_retry;
  logic             w_capture;
  logic             w_retry;
  logic             w_abort;
  logic             w_match;
`endif

  assign w_nib_a = r_a[4*r_idx +: 4];
  assign w_nib_b = r_b[4*r_idx +: 4];
  assign w_last  = (r_idx == LAST);

`ifdef CLA_RECHECK_EN
  assign w_active = (r_state == S_CALC) || (r_state == S_CHECK);
  assign w_match  = (cla_sum == r_sh_sum) && (cla_cout == r_sh_cout);
`else
  assign w_active = (r_state == S_CALC);
`endif

  // The CLA only sees operand bits while a nibble is in flight.
  assign cla_a   = w_active ? w_nib_a : 4'h0;
  assign cla_b   = w_active ? w_nib_b : 4'h0;
  assign cla_cin = w_active && ((r_idx == '0) ? r_cin0 : r_carry);

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

`ifdef CLA_RECHECK_EN
  assign err = r_err;
`else
  assign err = 1'b0;
  logic w_unused;
  assign w_unused = (MAX_RETRY > 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-cycle datapath strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_commit = 1'b0;
`ifdef CLA_RECHECK_EN
    w_capture = 1'b0;
    w_retry   = 1'b0;
    w_abort   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
`ifdef CLA_RECHECK_EN
      S_CALC: begin
        w_capture = 1'b1;
        w_next    = S_CHECK;
      end
      S_CHECK: begin
        if (w_match) begin
          w_commit = 1'b1;
          w_next   = w_last ? S_DONE : S_CALC;
        end else if (r_retry == RMAX) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end else begin
          w_retry = 1'b1;
          w_next  = S_CALC;
        end
      end
`else
      S_CALC: begin
        w_commit = 1'b1;
        if (w_last) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, nibble walk, carry chain and result assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_cin0  <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= op_a;
        r_b     <= op_b;
        r_cin0  <= op_cin;
        r_idx   <= '0;
        r_carry <= 1'b0;
        r_sum   <= '0;
        r_cout  <= 1'b0;
      end
      if (w_commit) begin
        r_sum[4*r_idx +: 4] <= cla_sum;
        r_carry             <= cla_cout;
        if (w_last) r_cout <= cla_cout;
        else        r_idx  <= r_idx + 1'b1;
      end
`ifdef CLA_RECHECK_EN
      // An exhausted retry budget yields a zeroed result.
      if (w_abort) begin
        r_sum  <= '0;
        r_cout <= 1'b0;
      end
`endif
    end
  end

`ifdef CLA_RECHECK_EN
  // Shadow copy, retry budget and abort flag for temporal checking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_sum  <= 4'h0;
      r_sh_cout <= 1'b0;
      r_retry   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_retry <= '0;
        r_err   <= 1'b0;
      end
      if (w_capture) begin
        r_sh_sum  <= cla_sum;
        r_sh_cout <= cla_cout;
      end
      if (w_commit) r_retry <= '0;
      if (w_retry)  r_retry <= r_retry + 1'b1;
      if (w_abort)  r_err   <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb_cla_word_sequencer: directed vectors against a behavioural 4-bit CLA.
// Recheck vectors run only when CLA_RECHECK_EN is defined.
module tb_cla_word_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;
`ifdef CLA_RECHECK_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;
  logic         busy;
  logic [3:0]   cla_a;
  logic [3:0]   cla_b;
  logic         cla_cin;
  logic [3:0]   cla_sum;
  logic         cla_cout;

  logic         inj = 1'b0;
  logic [4:0]   cla_full;

  assign cla_full = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};
  assign cla_sum  = inj ? 4'h0 : cla_full[3:0];
  assign cla_cout = cla_full[4];

  cla_word_sequencer #(.NIBBLES(N), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .busy(busy),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  logic [3:0] trace [0:31];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = c;
    tick();
    in_valid = 1'b0;
    op_a     = 16'hDEAD;
    op_b     = 16'hBEEF;
    op_cin   = 1'b1;
  endtask

  // mode 1: corrupt cycle 3 once; mode 2: corrupt cycles 1,3,5
  task automatic wait_done(input int mode, output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      if (lat < 32) trace[lat] = cla_a;
      inj = (mode == 1 && lat == 3) ||
            (mode == 2 && (lat == 1 || lat == 3 || lat == 5));
      tick();
      lat++;
    end
    inj = 1'b0;
    if (!out_valid) chk("timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [3:0] exp_t [0:3];
    exp_t[0] = 4'h4;
    exp_t[1] = 4'h3;
    exp_t[2] = 4'h2;
    exp_t[3] = 4'h1;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum",       {16'b0, sum},       32'd0);
    chk("rst_cout",      {31'b0, cout},      32'd0);
    chk("rst_err",       {31'b0, err},       32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_cla_a",     {28'b0, cla_a},     32'd0);
    chk("rst_cla_b",     {28'b0, cla_b},     32'd0);
    chk("rst_cla_cin",   {31'b0, cla_cin},   32'd0);

    // FFFF + 0001 wraps to zero with carry out
    start(16'hFFFF, 16'h0001, 1'b0);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    wait_done(0, lat);
    chk("t1_lat",  lat,                 4 * STEP);
    chk("t1_sum",  {16'b0, sum},        32'h0000);
    chk("t1_cout", {31'b0, cout},       32'd1);
    chk("t1_err",  {31'b0, err},        32'd0);
    drain();

    // 1234 + 4321 + 1, nibble walk 4,3,2,1 on cla_a
    start(16'h1234, 16'h4321, 1'b1);
    wait_done(0, lat);
    chk("t2_lat",  lat,           4 * STEP);
    chk("t2_sum",  {16'b0, sum},  32'h5556);
    chk("t2_cout", {31'b0, cout}, 32'd0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_nib%0d", k), {28'b0, trace[k*STEP]},
          {28'b0, exp_t[k]});
    drain();

    // 8000 + 8000 held in DONE with out_ready low
    start(16'h8000, 16'h8000, 1'b0);
    wait_done(0, lat);
    for (int k = 0; k < 5; k++) begin
      chk("t3_sum",      {16'b0, sum},       32'h0000);
      chk("t3_cout",     {31'b0, cout},      32'd1);
      chk("t3_out_valid",{31'b0, out_valid}, 32'd1);
      chk("t3_in_ready", {31'b0, in_ready},  32'd0);
      tick();
    end
    // a request offered during the output handshake is not taken
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_a      = 16'h0001;
    op_b      = 16'h0001;
    op_cin    = 1'b0;
    chk("t3_in_ready_hs", {31'b0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
    chk("t3_in_ready_after", {31'b0, in_ready},  32'd1);
    chk("t3_ov_after",       {31'b0, out_valid}, 32'd0);
    chk("t3_busy_after",     {31'b0, busy},      32'd0);
    tick();
    in_valid = 1'b0;
    op_a     = 16'hDEAD;
    op_b     = 16'hBEEF;
    wait_done(0, lat);
    chk("t3b_lat",  lat,           4 * STEP);
    chk("t3b_sum",  {16'b0, sum},  32'h0002);
    chk("t3b_cout", {31'b0, cout}, 32'd0);
    drain();

    // reset in the middle of nibble 2
    start(16'h1234, 16'h4321, 1'b0);
    for (int k = 0; k < 2 * STEP; k++) tick();
    chk("t4_nib2", {28'b0, cla_a}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_in_ready",  {31'b0, in_ready},  32'd1);
    chk("t4_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_busy",      {31'b0, busy},      32'd0);
    chk("t4_sum",       {16'b0, sum},       32'd0);
    chk("t4_cla_a",     {28'b0, cla_a},     32'd0);
    start(16'h0F0F, 16'h00F1, 1'b0);
    wait_done(0, lat);
    chk("t4_lat",  lat,           4 * STEP);
    chk("t4_sum2", {16'b0, sum},  32'h1000);
    chk("t4_cout", {31'b0, cout}, 32'd0);
    drain();

`ifdef CLA_RECHECK_EN
    // single transient fault in CHECK of nibble 1 is retried away
    start(16'h1111, 16'h2222, 1'b0);
    wait_done(1, lat);
    chk("r1_lat",  lat,           32'd10);
    chk("r1_sum",  {16'b0, sum},  32'h3333);
    chk("r1_cout", {31'b0, cout}, 32'd0);
    chk("r1_err",  {31'b0, err},  32'd0);
    drain();

    // persistent fault on nibble 0 exhausts retries
    start(16'h1111, 16'h2222, 1'b0);
    wait_done(2, lat);
    chk("r2_lat",  lat,           32'd6);
    chk("r2_err",  {31'b0, err},  32'd1);
    chk("r2_sum",  {16'b0, sum},  32'h0000);
    chk("r2_cout", {31'b0, cout}, 32'd0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_word_sequencer.md
# cla_word_sequencer

Multi-cycle controller that computes wide additions on the shared 4-bit carry look-ahead adder. It splits operands into nibbles, drives them through one external 4-bit CLA instance least-significant first, chains the carry between cycles and assembles the full sum. It sits between a valid/ready requester and the CLA datapath. An optional recompute-and-compare mode provides temporal fault detection with retry.

## Interface
- NIBBLES, 4: operand width in nibbles; WIDTH = 4*NIBBLES; legal range 2..16.
- MAX_RETRY, 2: retries allowed per nibble before abort; used only when CLA_RECHECK_EN is defined.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block accepts a request; high only in IDLE.
- op_a  input  WIDTH  addend A.
- op_b  input  WIDTH  addend B.
- op_cin  input  1  carry-in of the word add.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  registered word carry-out.
- err  output  1  registered abort flag; constant 0 without CLA_RECHECK_EN.
- busy  output  1  high in any state other than IDLE.
- cla_a  output  4  nibble A to CLA.
- cla_b  output  4  nibble B to CLA.
- cla_cin  output  1  carry to CLA.
- cla_sum  input  4  CLA sum, combinational from cla_a/cla_b/cla_cin.
- cla_cout  input  1  CLA carry-out.

## Operation
- States: IDLE, CALC, CHECK (only with CLA_RECHECK_EN), DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch op_a, op_b, op_cin; clear nibble index idx=0 and retry count; go to CALC.
- cla_a/cla_b drive nibble idx of the latched operands. cla_cin = latched op_cin for idx 0, else the stored chain carry. All three are 0 in IDLE and DONE.
- CALC without macro: capture cla_sum into sum[4*idx+3:4*idx] and cla_cout into the chain carry; idx++. At idx==NIBBLES-1, go to DONE with cout=cla_cout and out_valid=1.
- DONE: hold sum, cout, err and out_valid until out_ready, then go to IDLE with out_valid=0.
- A new request is never accepted in the same cycle as out_ready. in_ready rises the cycle after the output handshake.
- Operand inputs are ignored outside the accept cycle.
- Arithmetic is modulo 2^WIDTH. cout is the carry out of bit WIDTH-1.
- rst in any state: go to IDLE and discard the in-flight operation. Drops out_valid, sum, cout, err, busy, idx, retry count and chain carry to 0.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, sum=0, cout=0, err=0, busy=0, cla_a=0, cla_b=0, cla_cin=0.
- Accept at edge E0. Without macro, out_valid is high after edge E0+NIBBLES; latency is NIBBLES cycles.
- Minimum request-to-request period is NIBBLES+2 cycles with out_ready held high.
- With macro, fault-free latency is 2*NIBBLES cycles. Each retry adds 2 cycles.

## Configuration
- CLA_RECHECK_EN defined:
  - CALC stores cla_sum and cla_cout in a shadow register; the next state is CHECK.
  - CHECK re-presents the same nibble inputs and compares against the shadow.
  - On match: commit as in CALC, advance idx, return to CALC or go to DONE.
  - On mismatch: increment the retry count and return to CALC for the same nibble. The retry count clears on each nibble commit.
  - On a mismatch with retry count already equal to MAX_RETRY: go to DONE with err=1, sum=0, cout=0.
- CLA_RECHECK_EN undefined: no CHECK state, no shadow registers, err tied 0.

## Test plan
- NIBBLES=4, op_a=0xFFFF, op_b=0x0001, op_cin=0 -> sum=0x0000, cout=1, err=0. out_valid exactly 4 cycles after accept (8 with macro).
- op_a=0x1234, op_b=0x4321, op_cin=1 -> sum=0x5556, cout=0. Nibble index steps 0..3 on cla_a: 4,3,2,1.
- Hold out_ready=0 for 5 cycles after 0x8000+0x8000 -> sum=0x0000, cout=1 stable. in_ready=0 throughout; in_ready=1 the cycle after out_ready.
- Assert rst for 1 cycle while idx=2 -> next cycle IDLE, in_ready=1, out_valid=0. The following 0x0F0F+0x00F1 gives 0x1000, cout=0.
- Macro on: corrupt cla_sum to 0x0 during the CHECK cycle of nibble 1, once, for 0x1111+0x2222 -> sum=0x3333, err=0, latency 10 cycles.
- Macro on: corrupt cla_sum in every CHECK of nibble 0 with MAX_RETRY=2 -> err=1, sum=0, cout=0, out_valid after 3 CALC/CHECK pairs.
